div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 145 ++++++++++++++
 tb/tb_div.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle 32-bit divider for the EX stage: one restoring shift-subtract step per cycle,
// signed or unsigned, result packed as {remainder, quotient} and held while start stays high.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // Handshake: start_i is held high until ready_o is seen; ready_o high means result_o
  // is valid and stays so while start_i remains high. Dropping start_i releases the
  // block to FREE; annul_i abandons any operation immediately.

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } div_state_e;

  div_state_e  state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] dividend, dividend_n;
  logic [31:0] divisor, divisor_n;
  logic        sgn, sgn_n;
  logic        neg1, neg1_n;
  logic        neg2, neg2_n;
  logic [63:0] result_n;
  logic        ready_n;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] trial;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Partial remainder sits in dividend[64:33]; quotient bits shift in at the bottom.
  assign trial    = {1'b0, dividend[63:32]} - {1'b0, divisor};
  assign quot_raw = dividend[31:0];
  assign rem_raw  = dividend[64:33];
  assign quot_fix = (sgn && (neg1 ^ neg2)) ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fix  = (sgn && neg1) ? (~rem_raw + 32'd1) : rem_raw;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dividend_n = dividend;
    divisor_n  = divisor;
    sgn_n      = sgn;
    neg1_n     = neg1;
    neg2_n     = neg2;
    result_n   = 64'd0;
    ready_n    = 1'b0;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          cnt_n = 6'd0;
          if (opdata2_i == 32'd0) begin
            state_n = BYZERO;
          end else begin
            state_n    = ON;
            dividend_n = {32'd0, abs1, 1'b0};
            divisor_n  = abs2;
            sgn_n      = signed_div_i;
            neg1_n     = opdata1_i[31];
            neg2_n     = opdata2_i[31];
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_n = FREE;
        end else begin
          state_n    = END;
          dividend_n = 65'd0;
          sgn_n      = 1'b0;
          neg1_n     = 1'b0;
          neg2_n     = 1'b0;
        end
      end
      ON: begin
        if (annul_i) begin
          state_n = FREE;
        end else begin
          if (trial[32]) begin
            dividend_n = {dividend[63:0], 1'b0};
          end else begin
            dividend_n = {trial[31:0], dividend[31:0], 1'b1};
          end
          cnt_n = cnt + 6'd1;
          if (cnt == 6'd31) begin
            state_n = END;
          end
        end
      end
      END: begin
        // ready_o is registered, so it rises one edge after END is entered.
        if (annul_i) begin
          state_n = FREE;
        end else if (start_i) begin
          ready_n  = 1'b1;
          result_n = {rem_fix, quot_fix};
        end else begin
          state_n = FREE;
        end
      end
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      dividend <= 65'd0;
      divisor  <= 32'd0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dividend <= dividend_n;
      divisor  <= divisor_n;
      sgn      <= sgn_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed and randomized checks of the divider against an arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and the
  // remainder follows the dividend's sign, which is exactly the required result.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sg);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Driver: full transaction with latency, quiet-output, persistence and release checks.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input string tag);
    int lat;
    int want_lat;
    logic quiet;
    logic [63:0] exp;
    exp_q.push_back(model(a, b, sg));
    want_lat = (b == 32'd0) ? 2 : 33;
    opdata1 = a;
    opdata2 = b;
    signed_div = sg;
    start = 1'b1;
    tick();
    lat = 0;
    quiet = 1'b1;
    while (lat < 40) begin
      opdata1 = $urandom;
      opdata2 = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (ready) break;
      if (result !== 64'd0) quiet = 1'b0;
    end
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(want_lat));
    check({tag, " quiet"}, {63'd0, quiet}, 64'd1);
    check({tag, " result"}, result, exp);
    tick();
    check({tag, " hold"}, {result, 63'd0} | {63'd0, ready}, {exp, 63'd0} | 64'd1);
    check({tag, " hold result"}, result, exp);
    start = 1'b0;
    tick();
    check({tag, " release"}, {63'd0, ready} | result, 64'd0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    opdata1 = 32'd0;
    opdata2 = 32'd0;
    repeat (3) tick();
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_op(32'd100, 32'd7, 1'b0, "udiv 100/7");
    check("udiv 100/7 literal", model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, "sdiv -7/2");
    run_op(32'd5, 32'd0, 1'b0, "div by zero");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "sdiv overflow wrap");

    // Annul ten cycles into the iteration.
    opdata1 = 32'h12345678; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    repeat (40) tick();
    check("annul in ON stays idle", {63'd0, ready} | result, 64'd0);
    run_op(32'hFFFFFFFF, 32'h10, 1'b0, "after annul");

    // Annul while the result is being presented.
    opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
    repeat (34) tick();
    check("pre-annul END ready", {63'd0, ready}, 64'd1);
    annul = 1'b1;
    tick();
    check("annul in END", {63'd0, ready} | result, 64'd0);
    annul = 1'b0; start = 1'b0;
    tick();

    // Annul in BYZERO.
    opdata1 = 32'd9; opdata2 = 32'd0; start = 1'b1;
    tick();
    start = 1'b0; annul = 1'b1;
    tick();
    annul = 1'b0;
    repeat (4) tick();
    check("annul in BYZERO", {63'd0, ready} | result, 64'd0);

    // Reset mid-division.
    opdata1 = 32'hDEADBEEF; opdata2 = 32'd7; signed_div = 1'b1; start = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1; annul = 1'b1;
    tick();
    rst = 1'b0; annul = 1'b0; start = 1'b0;
    check("reset mid-op", {63'd0, ready} | result, 64'd0);
    repeat (40) tick();
    check("reset idle", {63'd0, ready} | result, 64'd0);
    run_op(32'd9, 32'd3, 1'b0, "after reset 9/3");

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("random %0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
